// File: rtl/axi_func_pkg.sv
// Shared AXI widths, burst/state enums and alignment, byte-lane and wrap-boundary helpers.
package axi_func_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 16;
    localparam int ID_WIDTH   = 12;
    localparam int NB         = DATA_WIDTH / 8;
    localparam int SIZE_MAX   = $clog2(NB);

    typedef enum logic [1:0] {FIXED, INCR, WRAP, RSVD} axi_burst_e;
    typedef enum logic {IDLE, BURST} gen_state_e;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    function automatic addr_t aligned_address(input addr_t a, input logic [2:0] size);
        addr_t mask;
        mask = (ADDR_WIDTH'(1) << size) - ADDR_WIDTH'(1);
        return a & ~mask;
    endfunction

    function automatic logic [NB-1:0] byte_lane_o(input addr_t a);
        addr_t t;
        t = a & ADDR_WIDTH'(NB - 1);
        return t[NB-1:0];
    endfunction

    // The first beat of an unaligned burst starts mid-word and ends at the size boundary.
    function automatic logic [NB-1:0] byte_lane_n(input addr_t a, input logic [2:0] size,
                                                  input logic first);
        addr_t nbytes;
        addr_t t;
        nbytes = ADDR_WIDTH'(1) << size;
        if (first)
            t = aligned_address(a, size) + nbytes - ADDR_WIDTH'(1)
                - (a & ~ADDR_WIDTH'(NB - 1));
        else
            t = (a & ADDR_WIDTH'(NB - 1)) + nbytes - ADDR_WIDTH'(1);
        return t[NB-1:0];
    endfunction

    function automatic addr_t lower_wrap_boundry(input addr_t a, input logic [2:0] size,
                                                 input logic [7:0] len);
        addr_t ws;
        ws = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
        return a & ~(ws - ADDR_WIDTH'(1));
    endfunction

    function automatic addr_t upper_wrap_boundry(input addr_t a, input logic [2:0] size,
                                                 input logic [7:0] len);
        addr_t ws;
        ws = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size;
        return lower_wrap_boundry(a, size, len) + ws;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen_if.sv
// AW input channel plus per-beat descriptor output channel of the burst expander.
interface axi_burst_addr_gen_if;
    import axi_func_pkg::*;

    logic                  s_awvalid;
    logic                  s_awready;
    logic [ADDR_WIDTH-1:0] s_awaddr;
    logic [7:0]            s_awlen;
    logic [2:0]            s_awsize;
    logic [1:0]            s_awburst;
    logic [ID_WIDTH-1:0]   s_awid;

    logic                  m_valid;
    logic                  m_ready;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [ID_WIDTH-1:0]   m_id;
    logic [NB-1:0]         m_lower_lane;
    logic [NB-1:0]         m_upper_lane;
    logic [NB-1:0]         m_strb;
    logic [7:0]            m_beat;
    logic                  m_last;
    logic                  m_err;

    modport slave (
        input  s_awvalid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awid, m_ready,
        output s_awready, m_valid, m_addr, m_id, m_lower_lane, m_upper_lane,
        output m_strb, m_beat, m_last, m_err
    );

    modport master (
        output s_awvalid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awid, m_ready,
        input  s_awready, m_valid, m_addr, m_id, m_lower_lane, m_upper_lane,
        input  m_strb, m_beat, m_last, m_err
    );

endinterface

// File: rtl/axi_beat_addr_calc.sv
// Combinational beat address, byte-lane and strobe calculation.
// Wrap-boundary handling only exists when AXI_WRAP_BURST_EN is defined.
module axi_beat_addr_calc
    import axi_func_pkg::*;
(
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    input  logic                  load,
`ifdef AXI_WRAP_BURST_EN
    input  logic [ADDR_WIDTH-1:0] wrap_lo,
    input  logic [ADDR_WIDTH-1:0] wrap_hi,
`endif
    output logic [ADDR_WIDTH-1:0] beat_addr,
    output logic [NB-1:0]         lower,
    output logic [NB-1:0]         upper,
    output logic [NB-1:0]         strb
);

    logic [ADDR_WIDTH-1:0] step;
    logic                  first;

    // load: lanes for addr itself; otherwise the following beat of the burst
    always_comb begin
        step      = aligned_address(addr, size) + (ADDR_WIDTH'(1) << size);
        beat_addr = addr;
        first     = 1'b1;
        if (!load && burst != FIXED) begin
            first     = 1'b0;
            beat_addr = step;
`ifdef AXI_WRAP_BURST_EN
            if (burst == WRAP && step == wrap_hi)
                beat_addr = wrap_lo;
`endif
        end
        lower = byte_lane_o(beat_addr);
        upper = byte_lane_n(beat_addr, size, first);
        for (int i = 0; i < NB; i++)
            strb[i] = (NB'(i) >= lower) && (NB'(i) <= upper);
    end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// AXI AW burst expander: one registered descriptor per write data beat.
// Define AXI_WRAP_BURST_EN to execute WRAP bursts; otherwise they run as INCR.
module axi_burst_addr_gen
    import axi_func_pkg::*;
(
    input logic               ACLK,
    input logic               ARESETn,
    axi_burst_addr_gen_if.slave bus
);

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_BURST = BURST;

    logic [0:0]            state;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [7:0]            len_q;
    logic                  aw_hs;
    logic                  load;
    logic [2:0]            size_eff;
    logic [1:0]            burst_eff;
    logic                  wrap_ok;
    logic                  err;
    logic [ADDR_WIDTH-1:0] calc_addr;
    logic [2:0]            calc_size;
    logic [1:0]            calc_burst;
    logic [ADDR_WIDTH-1:0] beat_addr;
    logic [NB-1:0]         lower;
    logic [NB-1:0]         upper;
    logic [NB-1:0]         strb;

    assign aw_hs    = bus.s_awvalid & bus.s_awready;
    assign load     = (state == ST_IDLE);
    assign size_eff = (bus.s_awsize > 3'(SIZE_MAX)) ? 3'(SIZE_MAX) : bus.s_awsize;

`ifdef AXI_WRAP_BURST_EN
    logic [ADDR_WIDTH-1:0] wrap_lo_q;
    logic [ADDR_WIDTH-1:0] wrap_hi_q;

    assign wrap_ok = (bus.s_awlen == 8'd1 || bus.s_awlen == 8'd3 ||
                      bus.s_awlen == 8'd7 || bus.s_awlen == 8'd15) &&
                     (bus.s_awaddr == aligned_address(bus.s_awaddr, size_eff));
`else
    assign wrap_ok = 1'b0;
`endif

    always_comb begin
        burst_eff = INCR;
        unique case (1'b1)
            (bus.s_awburst == FIXED): burst_eff = FIXED;
            (bus.s_awburst == WRAP):  burst_eff = wrap_ok ? WRAP : INCR;
            default:                  burst_eff = INCR;
        endcase
    end

    assign err = (bus.s_awsize > 3'(SIZE_MAX)) || (bus.s_awburst == RSVD) ||
                 (bus.s_awburst == WRAP && !wrap_ok);

    assign calc_addr  = load ? bus.s_awaddr : bus.m_addr;
    assign calc_size  = load ? size_eff : size_q;
    assign calc_burst = load ? burst_eff : burst_q;

    axi_beat_addr_calc u_calc (
        .addr      (calc_addr),
        .size      (calc_size),
        .burst     (calc_burst),
        .load      (load),
`ifdef AXI_WRAP_BURST_EN
        .wrap_lo   (wrap_lo_q),
        .wrap_hi   (wrap_hi_q),
`endif
        .beat_addr (beat_addr),
        .lower     (lower),
        .upper     (upper),
        .strb      (strb)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state            <= ST_IDLE;
            size_q           <= '0;
            burst_q          <= '0;
            len_q            <= '0;
            bus.s_awready    <= 1'b1;
            bus.m_valid      <= 1'b0;
            bus.m_addr       <= '0;
            bus.m_id         <= '0;
            bus.m_lower_lane <= '0;
            bus.m_upper_lane <= '0;
            bus.m_strb       <= '0;
            bus.m_beat       <= '0;
            bus.m_last       <= 1'b0;
            bus.m_err        <= 1'b0;
        end else begin
            bus.m_err <= 1'b0;
            if (state == ST_IDLE) begin
                if (aw_hs) begin
                    state            <= ST_BURST;
                    size_q           <= size_eff;
                    burst_q          <= burst_eff;
                    len_q            <= bus.s_awlen;
                    bus.s_awready    <= 1'b0;
                    bus.m_valid      <= 1'b1;
                    bus.m_addr       <= beat_addr;
                    bus.m_id         <= bus.s_awid;
                    bus.m_lower_lane <= lower;
                    bus.m_upper_lane <= upper;
                    bus.m_strb       <= strb;
                    bus.m_beat       <= 8'd0;
                    bus.m_last       <= (bus.s_awlen == 8'd0);
                    bus.m_err        <= err;
                end
            end else if (bus.m_ready) begin
                if (bus.m_last) begin
                    state         <= ST_IDLE;
                    bus.s_awready <= 1'b1;
                    bus.m_valid   <= 1'b0;
                end else begin
                    bus.m_addr       <= beat_addr;
                    bus.m_lower_lane <= lower;
                    bus.m_upper_lane <= upper;
                    bus.m_strb       <= strb;
                    bus.m_beat       <= bus.m_beat + 8'd1;
                    bus.m_last       <= (bus.m_beat + 8'd1 == len_q);
                end
            end
        end
    end

`ifdef AXI_WRAP_BURST_EN
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wrap_lo_q <= '0;
            wrap_hi_q <= '0;
        end else if (aw_hs) begin
            wrap_lo_q <= lower_wrap_boundry(bus.s_awaddr, size_eff, bus.s_awlen);
            wrap_hi_q <= upper_wrap_boundry(bus.s_awaddr, size_eff, bus.s_awlen);
        end
    end
`endif

endmodule

// File: tb/tb_axi_burst_addr_gen.sv
// Directed testbench for axi_burst_addr_gen; WRAP expectations follow AXI_WRAP_BURST_EN.
module tb_axi_burst_addr_gen;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    axi_burst_addr_gen_if bus ();

    axi_burst_addr_gen dut (
        .ACLK    (clk),
        .ARESETn (rst_n),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [15:0] a, input logic [3:0] s,
                        input logic [3:0] lo, input logic [3:0] hi,
                        input logic [7:0] b, input logic l);
        chk({tag, ".valid"}, 32'(bus.m_valid), 1);
        chk({tag, ".addr"}, 32'(bus.m_addr), 32'(a));
        chk({tag, ".strb"}, 32'(bus.m_strb), 32'(s));
        chk({tag, ".lo"}, 32'(bus.m_lower_lane), 32'(lo));
        chk({tag, ".hi"}, 32'(bus.m_upper_lane), 32'(hi));
        chk({tag, ".beat"}, 32'(bus.m_beat), 32'(b));
        chk({tag, ".last"}, 32'(bus.m_last), 32'(l));
    endtask

    task automatic send_aw(input string tag, input logic [15:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] bt,
                           input logic [11:0] id);
        chk({tag, ".awready"}, 32'(bus.s_awready), 1);
        bus.s_awaddr  = a;
        bus.s_awlen   = len;
        bus.s_awsize  = size;
        bus.s_awburst = bt;
        bus.s_awid    = id;
        bus.s_awvalid = 1'b1;
        tick();
        bus.s_awvalid = 1'b0;
    endtask

    task automatic burst_done(input string tag);
        tick();
        chk({tag, ".done_valid"}, 32'(bus.m_valid), 0);
        chk({tag, ".done_awready"}, 32'(bus.s_awready), 1);
    endtask

    initial begin
        bus.s_awvalid = 1'b0;
        bus.s_awaddr  = '0;
        bus.s_awlen   = '0;
        bus.s_awsize  = '0;
        bus.s_awburst = '0;
        bus.s_awid    = '0;
        bus.m_ready   = 1'b1;

        tick();
        tick();
        chk("rst.valid", 32'(bus.m_valid), 0);
        chk("rst.awready", 32'(bus.s_awready), 1);
        chk("rst.err", 32'(bus.m_err), 0);
        chk("rst.addr", 32'(bus.m_addr), 0);
        chk("rst.strb", 32'(bus.m_strb), 0);
        chk("rst.last", 32'(bus.m_last), 0);
        rst_n = 1'b1;
        tick();

        // INCR unaligned start
        send_aw("incr", 16'h0003, 8'd2, 3'd2, 2'd1, 12'hA5C);
        beat("incr0", 16'h0003, 4'b1000, 4'd3, 4'd3, 8'd0, 1'b0);
        chk("incr.id", 32'(bus.m_id), 32'h A5C);
        chk("incr.err", 32'(bus.m_err), 0);
        chk("incr.awready_busy", 32'(bus.s_awready), 0);
        tick();
        beat("incr1", 16'h0004, 4'b1111, 4'd0, 4'd3, 8'd1, 1'b0);
        tick();
        beat("incr2", 16'h0008, 4'b1111, 4'd0, 4'd3, 8'd2, 1'b1);
        burst_done("incr");

        // WRAP, legal len and aligned start
        send_aw("wrap", 16'h0038, 8'd3, 3'd2, 2'd2, 12'h001);
`ifdef AXI_WRAP_BURST_EN
        chk("wrap.err", 32'(bus.m_err), 0);
        beat("wrap0", 16'h0038, 4'b1111, 4'd0, 4'd3, 8'd0, 1'b0);
        tick();
        beat("wrap1", 16'h003C, 4'b1111, 4'd0, 4'd3, 8'd1, 1'b0);
        tick();
        beat("wrap2", 16'h0030, 4'b1111, 4'd0, 4'd3, 8'd2, 1'b0);
        tick();
        beat("wrap3", 16'h0034, 4'b1111, 4'd0, 4'd3, 8'd3, 1'b1);
`else
        chk("wrap.err", 32'(bus.m_err), 1);
        beat("wrap0", 16'h0038, 4'b1111, 4'd0, 4'd3, 8'd0, 1'b0);
        tick();
        chk("wrap.err_clr", 32'(bus.m_err), 0);
        beat("wrap1", 16'h003C, 4'b1111, 4'd0, 4'd3, 8'd1, 1'b0);
        tick();
        beat("wrap2", 16'h0040, 4'b1111, 4'd0, 4'd3, 8'd2, 1'b0);
        tick();
        beat("wrap3", 16'h0044, 4'b1111, 4'd0, 4'd3, 8'd3, 1'b1);
`endif
        burst_done("wrap");

        // WRAP with illegal len runs as INCR in either build
        send_aw("wbad", 16'h0040, 8'd2, 3'd2, 2'd2, 12'h002);
        chk("wbad.err", 32'(bus.m_err), 1);
        beat("wbad0", 16'h0040, 4'b1111, 4'd0, 4'd3, 8'd0, 1'b0);
        tick();
        tick();
        beat("wbad2", 16'h0048, 4'b1111, 4'd0, 4'd3, 8'd2, 1'b1);
        burst_done("wbad");

        // FIXED narrow
        send_aw("fix", 16'h0011, 8'd3, 3'd0, 2'd0, 12'h003);
        beat("fix0", 16'h0011, 4'b0010, 4'd1, 4'd1, 8'd0, 1'b0);
        tick();
        beat("fix1", 16'h0011, 4'b0010, 4'd1, 4'd1, 8'd1, 1'b0);
        tick();
        beat("fix2", 16'h0011, 4'b0010, 4'd1, 4'd1, 8'd2, 1'b0);
        tick();
        beat("fix3", 16'h0011, 4'b0010, 4'd1, 4'd1, 8'd3, 1'b1);
        burst_done("fix");

        // narrow INCR walking lanes across a word boundary
        send_aw("nar", 16'h0002, 8'd3, 3'd0, 2'd1, 12'h004);
        beat("nar0", 16'h0002, 4'b0100, 4'd2, 4'd2, 8'd0, 1'b0);
        tick();
        beat("nar1", 16'h0003, 4'b1000, 4'd3, 4'd3, 8'd1, 1'b0);
        tick();
        beat("nar2", 16'h0004, 4'b0001, 4'd0, 4'd0, 8'd2, 1'b0);
        tick();
        beat("nar3", 16'h0005, 4'b0010, 4'd1, 4'd1, 8'd3, 1'b1);
        burst_done("nar");

        // backpressure at beat 1
        send_aw("bp", 16'h0100, 8'd2, 3'd2, 2'd1, 12'h005);
        beat("bp0", 16'h0100, 4'b1111, 4'd0, 4'd3, 8'd0, 1'b0);
        tick();
        beat("bp1", 16'h0104, 4'b1111, 4'd0, 4'd3, 8'd1, 1'b0);
        bus.m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            beat("bp.hold", 16'h0104, 4'b1111, 4'd0, 4'd3, 8'd1, 1'b0);
            chk("bp.hold_awready", 32'(bus.s_awready), 0);
        end
        bus.m_ready = 1'b1;
        tick();
        beat("bp2", 16'h0108, 4'b1111, 4'd0, 4'd3, 8'd2, 1'b1);
        chk("bp.last_awready", 32'(bus.s_awready), 0);
        burst_done("bp");

        // reserved burst and oversize: INCR with size clamped to 2
        send_aw("rsv", 16'h0020, 8'd1, 3'd3, 2'd3, 12'h006);
        chk("rsv.err", 32'(bus.m_err), 1);
        beat("rsv0", 16'h0020, 4'b1111, 4'd0, 4'd3, 8'd0, 1'b0);
        tick();
        chk("rsv.err_clr", 32'(bus.m_err), 0);
        beat("rsv1", 16'h0024, 4'b1111, 4'd0, 4'd3, 8'd1, 1'b1);
        burst_done("rsv");

        // asynchronous reset mid-burst
        send_aw("ar", 16'h0040, 8'd3, 3'd2, 2'd1, 12'h007);
        tick();
        beat("ar1", 16'h0044, 4'b1111, 4'd0, 4'd3, 8'd1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("ar.valid", 32'(bus.m_valid), 0);
        chk("ar.awready", 32'(bus.s_awready), 1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar.post_valid", 32'(bus.m_valid), 0);
        chk("ar.post_awready", 32'(bus.s_awready), 1);

        // single beat after recovery
        send_aw("one", 16'h0007, 8'd0, 3'd0, 2'd1, 12'h008);
        beat("one0", 16'h0007, 4'b1000, 4'd3, 4'd3, 8'd0, 1'b1);
        chk("one.id", 32'(bus.m_id), 32'h008);
        burst_done("one");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
